// File: rtl/counter_pkg.sv
// Shared types and constants for the sync-load up-counter.
package counter_pkg;

  localparam int unsigned CNT_WIDTH      = 4;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD_VALUE = 4'd9;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/counter_4b_sync_load.sv
// Free-running up-counter; a synchronous load re-seeds it with a fixed constant.
module counter_4b_sync_load
  import counter_pkg::*;
#(
  parameter int unsigned           WIDTH      = CNT_WIDTH,
  parameter logic [WIDTH-1:0]      LOAD_VALUE = WIDTH'(CNT_LOAD_VALUE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_next;

  // Load wins over count; the increment wraps naturally at 2^WIDTH.
  always_comb begin
    q_next = q + WIDTH'(1);
    if (load) begin
      q_next = LOAD_VALUE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: tb/tb_counter_4b_sync_load.sv
// Directed self-checking bench for counter_4b_sync_load.
module tb_counter_4b_sync_load;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] q;

  int unsigned n_checks;
  int unsigned n_errors;

  counter_4b_sync_load #(
    .WIDTH      (4),
    .LOAD_VALUE (4'd9)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then sample on the falling edge.
  task automatic step(input logic ld);
    load = ld;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp;
    logic       ok;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    load  = 1'b0;

    // Reset state, then count 1..5.
    repeat (2) @(negedge clk);
    check("reset", q, 4'd0);
    rst_n = 1'b1;
    for (int unsigned i = 1; i <= 5; i++) begin
      step(1'b0);
      exp = 4'(i);
      check("count", q, exp);
    end

    // Single-edge load, then resume counting from 10.
    step(1'b1);
    check("load1", q, 4'd9);
    step(1'b0);
    check("after_load_a", q, 4'd10);
    step(1'b0);
    check("after_load_b", q, 4'd11);

    // Held load keeps q at 9; release gives 10.
    for (int unsigned i = 0; i < 6; i++) begin
      step(1'b1);
      check("load_hold", q, 4'd9);
    end
    step(1'b0);
    check("load_release", q, 4'd10);

    // Fresh reset, 31 edges covering a wrap, then load from 15.
    rst_n = 1'b0;
    @(negedge clk);
    check("reset2", q, 4'd0);
    rst_n = 1'b1;
    for (int unsigned i = 1; i <= 31; i++) begin
      step(1'b0);
      exp = 4'(i);
      check("wrap_seq", q, exp);
    end
    step(1'b1);
    check("load_from_f", q, 4'd9);

    // Count to 12, then async reset between edges.
    for (int unsigned i = 0; i < 3; i++) step(1'b0);
    check("pre_async", q, 4'd12);
    #2;
    load  = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_reset", q, 4'd0);
    @(posedge clk);
    @(negedge clk);
    check("reset_beats_load", q, 4'd0);
    step(1'b1);
    check("reset_hold_load", q, 4'd0);
    rst_n = 1'b1;
    step(1'b1);
    check("release_with_load", q, 4'd9);

    // Reset released exactly at the edge: q must be 0 or 9, never X.
    rst_n = 1'b0;
    load  = 1'b1;
    @(negedge clk);
    @(posedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ok = !$isunknown(q) && (q == 4'd0 || q == 4'd9);
    check("edge_release_no_x", {3'b000, ok}, 4'd1);
    step(1'b1);
    check("edge_release_then_load", q, 4'd9);
    step(1'b0);
    check("edge_release_count", q, 4'd10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
